nr_step_update: RTL and testbench
=================================

Name: nr_step_update

Overview:
- Consumer of the Jacobian-inverse result: it pairs with the inverse-Jacobian block and performs one Newton-Raphson iteration step.
- Sequence: latches the current estimate (x,y,z) and residual F, requests the inverse-Jacobian block, and waits for its done pulse.
- Then computes delta = inv_det * (Aj * F) and outputs (x,y,z) - delta, with convergence and timeout flags.
- All data is signed Q8.24 fixed point.

Parameters:
- dw, 32, data width (Q8.24 at 32)
- FRAC, 24, fractional bits; product slice is [dw+FRAC-1:FRAC]
- TOL, 32'h0000_0100, convergence tolerance on |delta_i|
- TIMEOUT, 1024, max cycles to wait for inv_done

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one iteration step; sampled only in IDLE
- x, y, z  in  dw  current estimate, signed Q8.24
- f0, f1, f2  in  dw  residual F(x,y,z), signed Q8.24
- inv_en  out  1  one-cycle request pulse to the inverse-Jacobian block
- jx, jy, jz  out  dw  latched estimate driven to the inverse-Jacobian block
- inv_done  in  1  one-cycle done pulse from the inverse-Jacobian block
- inv_det  in  dw  reciprocal determinant, signed Q8.24, valid when inv_done=1
- Aj00..Aj22  in  dw each (9 ports)  adjugate entries, row-major Aj{r}{c}, valid when inv_done=1
- x_n, y_n, z_n  out  dw  updated estimate
- busy  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse; x_n/y_n/z_n and conv_o valid
- conv_o  out  1  all |delta_i| < TOL for the last step
- err_o  out  1  timeout on inv_done; sticky until the next accepted start

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0: inv_en, busy, done_o, conv_o, err_o, jx..jz, x_n..z_n. All internal registers 0.
- States: IDLE, REQ, WAIT, ROW0, ROW1, ROW2, SCALE, UPDATE, DONE.
- IDLE: on start=1:
  - latch x,y,z into jx,jy,jz and f0..f2 into F regs;
  - clear err_o and conv_o;
  - go to REQ.
- start while busy is ignored.
- REQ: inv_en=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - inv_done=1: latch all 9 Aj entries and inv_det; go to ROW0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without inv_done: set err_o=1, go to IDLE, no done_o.
- ROWr (r=0..2): t_r = sum over c of (Aj{r}{c} * F_c)[dw+FRAC-1:FRAC].
  - Each product is 2*dw wide.
  - The three slices are summed in dw bits with wrap-around (no saturation).
  - One row per cycle: three multipliers are shared across rows.
- SCALE: d_r = (inv_det * t_r)[dw+FRAC-1:FRAC] for r=0..2, computed in parallel in one cycle.
- UPDATE:
  - x_n = jx - d0, y_n = jy - d1, z_n = jz - d2, in dw bits with wrap-around.
  - conv_o = (|d0|<TOL) && (|d1|<TOL) && (|d2|<TOL), where |.| is two's-complement negate when the MSB is set.
  - The most-negative value is treated as not converged.
- DONE: done_o=1 this cycle only; go to IDLE. A start in this cycle is ignored.
- Latency: inv_done sampled high in cycle k gives done_o high in cycle k+6. start in cycle s gives inv_en high in cycle s+1.
- x_n..z_n and conv_o hold their values until the next UPDATE.
- jx..jz hold from start until the next accepted start. The inverse block may sample them at any time from inv_en until inv_done.
- A spurious inv_done outside WAIT is ignored.
- Reset asserted mid-operation (any state) returns to IDLE with all outputs zeroed. The in-flight step is abandoned.

Decomposition:
- Shared package (nr_pkg):
  - state encoding localparams;
  - Q8.24 constants: ONE=32'h0100_0000, HALF=32'h0080_0000;
  - FRAC;
  - fixed-point multiply-and-slice function fx_mul(a,b) returning (a*b)[dw+FRAC-1:FRAC].
- One sub-module: nr_dot3. It is a 3-term fixed-point dot product, combinational, instantiated once and shared across ROW0..ROW2 through an operand mux. The SCALE multipliers use fx_mul directly.

Test Plan:
- Identity step: x=y=z=ONE; F=(0x0080_0000, 0x0040_0000, 0xFF00_0000); Aj=ONE*I; inv_det=ONE; inv_done 3 cycles after inv_en -> done_o at inv_done+6; x_n=0x0080_0000, y_n=0x00C0_0000, z_n=0x0200_0000; conv_o=0.
- Scaling: Aj=0x0200_0000*I, inv_det=HALF, same x and F -> same x_n/y_n/z_n as the identity step.
- Convergence: F=(0x10, 0x10, 0x10), Aj=ONE*I, inv_det=ONE -> conv_o=1; x_n=ONE-0x10 on all three lanes.
- Timeout: inv_done held 0 -> err_o=1 exactly TIMEOUT cycles after WAIT entry; no done_o; busy=0. A following start clears err_o.
- Reset mid-step: assert rst=0 during ROW1 -> all outputs 0 immediately. After release, a full identity step completes correctly.
- Protocol edges:
  - start held high for 20 cycles -> exactly one inv_en per step;
  - inv_done pulsed in IDLE -> ignored;
  - start in the DONE cycle -> ignored.

Source files
------------

// File: rtl/nr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nr_pkg
//  Description : Shared definitions for the Newton-Raphson step update:
//                FSM state encoding, Q8.24 constants and the fixed-point
//                multiply-and-slice helper used by the datapath.
//  Revision    : 1.0  initial release
// ============================================================================
package nr_pkg;

    // Datapath width and fractional bits of the Q8.24 format.
    localparam int NR_DW = 32;
    localparam int FRAC  = 24;

    // Q8.24 constants.
    localparam logic [NR_DW-1:0] ONE  = 32'h0100_0000;
    localparam logic [NR_DW-1:0] HALF = 32'h0080_0000;

    // State encoding.
    localparam int ST_W = 4;
    localparam logic [ST_W-1:0] C_ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] C_ST_REQ    = 4'd1;
    localparam logic [ST_W-1:0] C_ST_WAIT   = 4'd2;
    localparam logic [ST_W-1:0] C_ST_ROW0   = 4'd3;
    localparam logic [ST_W-1:0] C_ST_ROW1   = 4'd4;
    localparam logic [ST_W-1:0] C_ST_ROW2   = 4'd5;
    localparam logic [ST_W-1:0] C_ST_SCALE  = 4'd6;
    localparam logic [ST_W-1:0] C_ST_UPDATE = 4'd7;
    localparam logic [ST_W-1:0] C_ST_DONE   = 4'd8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_REQ    = C_ST_REQ,
        ST_WAIT   = C_ST_WAIT,
        ST_ROW0   = C_ST_ROW0,
        ST_ROW1   = C_ST_ROW1,
        ST_ROW2   = C_ST_ROW2,
        ST_SCALE  = C_ST_SCALE,
        ST_UPDATE = C_ST_UPDATE,
        ST_DONE   = C_ST_DONE
    } nr_state_t;

    // Signed Q8.24 multiply: full 2*NR_DW product, bits [NR_DW+FRAC-1:FRAC]
    // returned. Both operands are sign-extended explicitly so the low
    // 2*NR_DW bits of the product equal the exact signed product.
    function automatic logic [NR_DW-1:0] fx_mul(input logic [NR_DW-1:0] a,
                                                input logic [NR_DW-1:0] b);
        logic signed [2*NR_DW-1:0] p;
        p = $signed({{NR_DW{a[NR_DW-1]}}, a}) * $signed({{NR_DW{b[NR_DW-1]}}, b});
        return NR_DW'(p >>> FRAC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nr_dot3.sv
`default_nettype none
// ============================================================================
//  Module      : nr_dot3
//  Description : Combinational 3-term signed Q8.24 dot product. Each product
//                is sliced back to Q8.24 before summing; the sum wraps in
//                NR_DW bits (no saturation).
//  Ports       : a0..a2  in   row operands (adjugate row)
//                b0..b2  in   column operands (residual vector)
//                sum     out  a0*b0 + a1*b1 + a2*b2, Q8.24
//  Revision    : 1.0  initial release
// ============================================================================
module nr_dot3
    import nr_pkg::*;
(
    input  logic [NR_DW-1:0] a0,
    input  logic [NR_DW-1:0] a1,
    input  logic [NR_DW-1:0] a2,
    input  logic [NR_DW-1:0] b0,
    input  logic [NR_DW-1:0] b1,
    input  logic [NR_DW-1:0] b2,
    output logic [NR_DW-1:0] sum
);

    assign sum = fx_mul(a0, b0) + fx_mul(a1, b1) + fx_mul(a2, b2);

endmodule
`default_nettype wire

// File: rtl/nr_step_update.sv
`default_nettype none
// ============================================================================
//  Module      : nr_step_update
//  Description : One Newton-Raphson iteration step. Latches the estimate and
//                residual, requests the inverse-Jacobian block, then forms
//                delta = inv_det * (Aj * F) and outputs estimate - delta with
//                convergence and timeout flags. Signed Q8.24 throughout.
//  Ports       : clk, rst (async, active low)
//                start            in   begin a step (sampled in IDLE only)
//                x, y, z          in   current estimate
//                f0, f1, f2       in   residual F(x,y,z)
//                inv_en           out  one-cycle request to inverse block
//                jx, jy, jz       out  latched estimate for inverse block
//                inv_done         in   one-cycle done from inverse block
//                inv_det, Aj00..Aj22 in  reciprocal det and adjugate
//                x_n, y_n, z_n    out  updated estimate
//                busy             out  high outside IDLE
//                done_o           out  one-cycle result-valid pulse
//                conv_o           out  all |delta_i| < TOL
//                err_o            out  inv_done timeout, sticky to next start
//  Revision    : 1.0  initial release
// ============================================================================
module nr_step_update
    import nr_pkg::*;
#(
    parameter int            DW      = NR_DW,
    parameter logic [DW-1:0] TOL     = 32'h0000_0100,
    parameter int            TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] z,
    input  logic [DW-1:0] f0,
    input  logic [DW-1:0] f1,
    input  logic [DW-1:0] f2,
    output logic          inv_en,
    output logic [DW-1:0] jx,
    output logic [DW-1:0] jy,
    output logic [DW-1:0] jz,
    input  logic          inv_done,
    input  logic [DW-1:0] inv_det,
    input  logic [DW-1:0] Aj00,
    input  logic [DW-1:0] Aj01,
    input  logic [DW-1:0] Aj02,
    input  logic [DW-1:0] Aj10,
    input  logic [DW-1:0] Aj11,
    input  logic [DW-1:0] Aj12,
    input  logic [DW-1:0] Aj20,
    input  logic [DW-1:0] Aj21,
    input  logic [DW-1:0] Aj22,
    output logic [DW-1:0] x_n,
    output logic [DW-1:0] y_n,
    output logic [DW-1:0] z_n,
    output logic          busy,
    output logic          done_o,
    output logic          conv_o,
    output logic          err_o
);

    // Counter covers 0..TIMEOUT-1 wait cycles.
    localparam int            CNT_W      = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    nr_state_t        r_state;
    nr_state_t        w_state_nxt;

    logic [DW-1:0]    r_jx, r_jy, r_jz;
    logic [DW-1:0]    r_f0, r_f1, r_f2;
    logic [DW-1:0]    r_aj [9];
    logic [DW-1:0]    r_det;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_t0, r_t1, r_t2;
    logic [DW-1:0]    r_d0, r_d1, r_d2;
    logic [DW-1:0]    r_xn, r_yn, r_zn;
    logic             r_conv;
    logic             r_err;

    logic [DW-1:0]    w_a0, w_a1, w_a2;
    logic [DW-1:0]    w_dot;
    logic [DW-1:0]    w_abs0, w_abs1, w_abs2;
    logic             w_conv;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        inv_en      = 1'b0;
        busy        = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                inv_en      = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // inv_done wins over an expiring counter in the same cycle.
                if (inv_done) begin
                    w_state_nxt = ST_ROW0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ROW0:   w_state_nxt = ST_ROW1;
            ST_ROW1:   w_state_nxt = ST_ROW2;
            ST_ROW2:   w_state_nxt = ST_SCALE;
            ST_SCALE:  w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = ST_DONE;
            ST_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared dot-product: one adjugate row per ROW state against F.
    // ------------------------------------------------------------------
    always_comb begin
        w_a0 = r_aj[0];
        w_a1 = r_aj[1];
        w_a2 = r_aj[2];
        case (r_state)
            ST_ROW1: begin
                w_a0 = r_aj[3];
                w_a1 = r_aj[4];
                w_a2 = r_aj[5];
            end
            ST_ROW2: begin
                w_a0 = r_aj[6];
                w_a1 = r_aj[7];
                w_a2 = r_aj[8];
            end
            default: ;
        endcase
    end

    nr_dot3 u_dot3 (
        .a0  (w_a0),
        .a1  (w_a1),
        .a2  (w_a2),
        .b0  (r_f0),
        .b1  (r_f1),
        .b2  (r_f2),
        .sum (w_dot)
    );

    // ------------------------------------------------------------------
    // Convergence: two's-complement magnitude compared unsigned, so the
    // most-negative delta (whose negation is itself) never converges.
    // ------------------------------------------------------------------
    always_comb begin
        w_abs0 = r_d0[DW-1] ? (-r_d0) : r_d0;
        w_abs1 = r_d1[DW-1] ? (-r_d1) : r_d1;
        w_abs2 = r_d2[DW-1] ? (-r_d2) : r_d2;
        w_conv = (w_abs0 < TOL) && (w_abs1 < TOL) && (w_abs2 < TOL);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_jx   <= '0;
            r_jy   <= '0;
            r_jz   <= '0;
            r_f0   <= '0;
            r_f1   <= '0;
            r_f2   <= '0;
            r_det  <= '0;
            r_cnt  <= '0;
            r_t0   <= '0;
            r_t1   <= '0;
            r_t2   <= '0;
            r_d0   <= '0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_xn   <= '0;
            r_yn   <= '0;
            r_zn   <= '0;
            r_conv <= 1'b0;
            r_err  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_aj[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_jx   <= x;
                        r_jy   <= y;
                        r_jz   <= z;
                        r_f0   <= f0;
                        r_f1   <= f1;
                        r_f2   <= f2;
                        r_err  <= 1'b0;
                        r_conv <= 1'b0;
                    end
                end
                ST_REQ: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    if (inv_done) begin
                        r_aj[0] <= Aj00;
                        r_aj[1] <= Aj01;
                        r_aj[2] <= Aj02;
                        r_aj[3] <= Aj10;
                        r_aj[4] <= Aj11;
                        r_aj[5] <= Aj12;
                        r_aj[6] <= Aj20;
                        r_aj[7] <= Aj21;
                        r_aj[8] <= Aj22;
                        r_det   <= inv_det;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_ROW0: r_t0 <= w_dot;
                ST_ROW1: r_t1 <= w_dot;
                ST_ROW2: r_t2 <= w_dot;
                ST_SCALE: begin
                    r_d0 <= fx_mul(r_det, r_t0);
                    r_d1 <= fx_mul(r_det, r_t1);
                    r_d2 <= fx_mul(r_det, r_t2);
                end
                ST_UPDATE: begin
                    r_xn   <= r_jx - r_d0;
                    r_yn   <= r_jy - r_d1;
                    r_zn   <= r_jz - r_d2;
                    r_conv <= w_conv;
                end
                default: ;
            endcase
        end
    end

    assign jx     = r_jx;
    assign jy     = r_jy;
    assign jz     = r_jz;
    assign x_n    = r_xn;
    assign y_n    = r_yn;
    assign z_n    = r_zn;
    assign conv_o = r_conv;
    assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_nr_step_update.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nr_step_update
//  Description : Self-checking bench for nr_step_update. Acts as the
//                inverse-Jacobian block, applies a table of directed steps,
//                protocol corner sequences and randomized steps compared
//                against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nr_step_update;
    import nr_pkg::*;

    localparam int TIMEOUT = 1024;
    localparam logic [31:0] TOL = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       x = '0, y = '0, z = '0;
    logic [31:0]       f0 = '0, f1 = '0, f2 = '0;
    logic              inv_en;
    logic [31:0]       jx, jy, jz;
    logic              inv_done = 1'b0;
    logic [31:0]       inv_det = '0;
    logic [8:0][31:0]  aj_drv = '0;
    logic [31:0]       x_n, y_n, z_n;
    logic              busy, done_o, conv_o, err_o;

    int n_chk = 0;
    int n_err = 0;
    int n_en = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inv_en) n_en++;
        if (done_o) n_done++;
    end

    nr_step_update #(.DW(32), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x(x), .y(y), .z(z), .f0(f0), .f1(f1), .f2(f2),
        .inv_en(inv_en), .jx(jx), .jy(jy), .jz(jz),
        .inv_done(inv_done), .inv_det(inv_det),
        .Aj00(aj_drv[0]), .Aj01(aj_drv[1]), .Aj02(aj_drv[2]),
        .Aj10(aj_drv[3]), .Aj11(aj_drv[4]), .Aj12(aj_drv[5]),
        .Aj20(aj_drv[6]), .Aj21(aj_drv[7]), .Aj22(aj_drv[8]),
        .x_n(x_n), .y_n(y_n), .z_n(z_n),
        .busy(busy), .done_o(done_o), .conv_o(conv_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [31:0]      x, y, z;
        logic [2:0][31:0] f;
        logic [8:0][31:0] aj;
        logic [31:0]      det;
        logic [7:0]       dly;
        logic [31:0]      xn, yn, zn;
        logic             conv;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0][31:0] f3(input logic [31:0] a, b, c);
        logic [2:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c;
        return r;
    endfunction

    function automatic logic [8:0][31:0] diag(input logic [31:0] v);
        logic [8:0][31:0] r;
        r = '0;
        r[0] = v; r[4] = v; r[8] = v;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [31:0] vx, vy, vz, input logic [2:0][31:0] vf,
                                 input logic [8:0][31:0] va, input logic [31:0] vd, input int dly,
                                 input logic [31:0] ex, ey, ez, input logic ec);
        vec_t v;
        v.x = vx; v.y = vy; v.z = vz; v.f = vf; v.aj = va; v.det = vd; v.dly = 8'(dly);
        v.xn = ex; v.yn = ey; v.zn = ez; v.conv = ec;
        return v;
    endfunction

    // Reference: t = Aj*F, delta = inv_det*t, each product rescaled from
    // Q16.48 to Q8.24 and truncated to 32 bits; result = estimate - delta.
    task automatic model(input logic [31:0] vx, vy, vz, input logic [2:0][31:0] vf,
                         input logic [8:0][31:0] va, input logic [31:0] vd,
                         output logic [31:0] ex, ey, ez, output logic ec);
        int     t [3];
        int     d [3];
        int     est [3];
        longint mag;
        est[0] = vx; est[1] = vy; est[2] = vz;
        ec = 1'b1;
        for (int r = 0; r < 3; r++) begin
            t[r] = 0;
            for (int c = 0; c < 3; c++)
                t[r] += int'((longint'($signed(va[r*3+c])) * longint'($signed(vf[c]))) >>> 24);
            d[r] = int'((longint'($signed(vd)) * longint'(t[r])) >>> 24);
            mag = (d[r] < 0) ? -longint'(d[r]) : longint'(d[r]);
            if (mag >= longint'(TOL)) ec = 1'b0;
            est[r] = est[r] - d[r];
        end
        ex = est[0]; ey = est[1]; ez = est[2];
    endtask

    // Drives one full step from IDLE; returns in the done_o cycle.
    task automatic run_step(input logic [31:0] vx, vy, vz, input logic [2:0][31:0] vf,
                            input logic [8:0][31:0] va, input logic [31:0] vd, input int dly,
                            input string tag,
                            output logic [31:0] gx, gy, gz, output logic gc);
        int seen;
        x = vx; y = vy; z = vz;
        f0 = vf[0]; f1 = vf[1]; f2 = vf[2];
        start = 1'b1;
        tick();
        start = 1'b0;
        x = $urandom; y = $urandom; z = $urandom;
        f0 = $urandom; f1 = $urandom; f2 = $urandom;
        chk({tag, " inv_en"}, 32'(inv_en), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        repeat (dly) tick();
        chk({tag, " jx"}, jx, vx);
        chk({tag, " jy"}, jy, vy);
        chk({tag, " jz"}, jz, vz);
        aj_drv = va;
        inv_det = vd;
        inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        for (int i = 0; i < 9; i++) aj_drv[i] = $urandom;
        inv_det = $urandom;
        seen = 0;
        for (int c = 1; c <= 8; c++) begin
            if (done_o) begin
                seen = c;
                break;
            end
            tick();
        end
        chk({tag, " done latency"}, 32'(seen), 32'd6);
        gx = x_n; gy = y_n; gz = z_n; gc = conv_o;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " ctl"}, {27'd0, inv_en, busy, done_o, conv_o, err_o}, 32'd0);
        chk({tag, " jx"}, jx, 32'd0);
        chk({tag, " jy"}, jy, 32'd0);
        chk({tag, " jz"}, jz, 32'd0);
        chk({tag, " x_n"}, x_n, 32'd0);
        chk({tag, " y_n"}, y_n, 32'd0);
        chk({tag, " z_n"}, z_n, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gx, gy, gz, ex, ey, ez;
        logic        gc, ec;
        logic [2:0][31:0] rf;
        logic [8:0][31:0] ra;
        logic [31:0] rd;
        int en0, done0, first;

        vecs[0] = mkv(ONE, ONE, ONE, f3(32'h0080_0000, 32'h0040_0000, 32'hFF00_0000), diag(ONE), ONE, 3,
                      32'h0080_0000, 32'h00C0_0000, 32'h0200_0000, 1'b0);
        vecs[1] = mkv(ONE, ONE, ONE, f3(32'h0080_0000, 32'h0040_0000, 32'hFF00_0000), diag(32'h0200_0000), HALF, 2,
                      32'h0080_0000, 32'h00C0_0000, 32'h0200_0000, 1'b0);
        vecs[2] = mkv(ONE, ONE, ONE, f3(32'h10, 32'h10, 32'h10), diag(ONE), ONE, 1,
                      32'h00FF_FFF0, 32'h00FF_FFF0, 32'h00FF_FFF0, 1'b1);
        ra = '0;
        ra[0] = ONE; ra[1] = ONE; ra[2] = ONE; ra[3] = ONE; ra[5] = 32'hFF00_0000;
        vecs[3] = mkv(0, 0, 0, f3(ONE, ONE, ONE), ra, HALF, 5,
                      32'hFE80_0000, 32'h0, 32'h0, 1'b0);
        vecs[4] = mkv(0, 0, 0, f3(32'h8000_0000, 0, 0), diag(ONE), ONE, 4,
                      32'h8000_0000, 32'h0, 32'h0, 1'b0);
        vecs[5] = mkv(ONE, ONE, ONE, f3(32'hFF, 0, 32'hFFFF_FF01), diag(ONE), ONE, 2,
                      32'h00FF_FF01, 32'h0100_0000, 32'h0100_00FF, 1'b1);
        vecs[6] = mkv(ONE, ONE, ONE, f3(32'h100, 0, 0), diag(ONE), ONE, 3,
                      32'h00FF_FF00, 32'h0100_0000, 32'h0100_0000, 1'b0);
        vecs[7] = mkv(ONE, ONE, ONE, f3(0, 0, 32'hFFFF_FF00), diag(ONE), ONE, 1,
                      32'h0100_0000, 32'h0100_0000, 32'h0100_0100, 1'b0);

        // Reset state
        x = 32'h1234_5678; f0 = 32'h1111_1111; start = 1'b1;
        repeat (3) tick();
        check_zero("reset");
        start = 1'b0;
        rst = 1'b1;
        tick();

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_step(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].f, vecs[i].aj, vecs[i].det,
                     int'(vecs[i].dly), $sformatf("vec%0d", i), gx, gy, gz, gc);
            chk($sformatf("vec%0d x_n", i), gx, vecs[i].xn);
            chk($sformatf("vec%0d y_n", i), gy, vecs[i].yn);
            chk($sformatf("vec%0d z_n", i), gz, vecs[i].zn);
            chk($sformatf("vec%0d conv", i), 32'(gc), 32'(vecs[i].conv));
            chk($sformatf("vec%0d err", i), 32'(err_o), 32'd0);
            tick();
        end

        // Start in the DONE cycle is ignored (last vector ended in DONE+1;
        // run another step and hit its DONE cycle).
        run_step(ONE, ONE, ONE, vecs[0].f, diag(ONE), ONE, 2, "pre_done", gx, gy, gz, gc);
        en0 = n_en;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start busy", 32'(busy), 32'd0);
        tick();
        chk("done_start inv_en", 32'(inv_en), 32'd0);
        tick();
        chk("done_start en count", 32'(n_en - en0), 32'd0);

        // Spurious inv_done in IDLE
        done0 = n_done;
        aj_drv = diag(32'h7000_0000);
        inv_det = 32'h7000_0000;
        inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        repeat (3) tick();
        chk("idle_done busy", 32'(busy), 32'd0);
        chk("idle_done done count", 32'(n_done - done0), 32'd0);
        chk("idle_done x_n hold", x_n, 32'h0080_0000);
        chk("idle_done z_n hold", z_n, 32'h0200_0000);

        // Start held high for 20 cycles: one request only
        en0 = n_en;
        x = ONE; y = ONE; z = ONE;
        f0 = 32'h0080_0000; f1 = 32'h0040_0000; f2 = 32'hFF00_0000;
        start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        aj_drv = diag(ONE);
        inv_det = ONE;
        inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        first = 0;
        for (int c = 1; c <= 8; c++) begin
            if (done_o) begin
                first = c;
                break;
            end
            tick();
        end
        chk("held_start latency", 32'(first), 32'd6);
        chk("held_start en count", 32'(n_en - en0), 32'd1);
        chk("held_start y_n", y_n, 32'h00C0_0000);
        tick();

        // Timeout
        en0 = n_en;
        done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo inv_en", 32'(inv_en), 32'd1);
        first = 0;
        for (int c = 1; c <= TIMEOUT + 10; c++) begin
            tick();
            if (err_o) begin
                first = c;
                break;
            end
        end
        chk("tmo err cycle", 32'(first), 32'(TIMEOUT + 1));
        chk("tmo busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("tmo err sticky", 32'(err_o), 32'd1);
        chk("tmo no done", 32'(n_done - done0), 32'd0);
        chk("tmo one request", 32'(n_en - en0), 32'd1);
        x = ONE; start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo err cleared", 32'(err_o), 32'd0);
        tick();
        aj_drv = diag(ONE); inv_det = ONE; inv_done = 1'b1;
        tick();
        inv_done = 1'b0;
        repeat (8) tick();
        chk("tmo recover idle", 32'(busy), 32'd0);

        // Reset during ROW1
        x = ONE; y = ONE; z = ONE;
        f0 = 32'h0080_0000; f1 = 32'h0040_0000; f2 = 32'hFF00_0000;
        start = 1'b1;
        tick();                      // REQ
        start = 1'b0;
        tick();                      // WAIT
        aj_drv = diag(ONE); inv_det = ONE; inv_done = 1'b1;
        tick();                      // ROW0
        inv_done = 1'b0;
        tick();                      // ROW1
        chk("rst_mid busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        tick();
        rst = 1'b1;
        tick();
        run_step(ONE, ONE, ONE, f3(32'h0080_0000, 32'h0040_0000, 32'hFF00_0000), diag(ONE), ONE, 3,
                 "post_rst", gx, gy, gz, gc);
        chk("post_rst x_n", gx, 32'h0080_0000);
        chk("post_rst y_n", gy, 32'h00C0_0000);
        chk("post_rst z_n", gz, 32'h0200_0000);
        chk("post_rst conv", 32'(gc), 32'd0);
        tick();

        // Randomized steps against the reference model
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 3; i++) rf[i] = (n % 3 == 0) ? 32'($urandom_range(0, 511)) - 32'd256 : $urandom;
            if (n % 3 == 0) begin
                ra = diag(ONE);
                rd = ONE;
            end else begin
                for (int i = 0; i < 9; i++) ra[i] = $urandom;
                rd = $urandom;
            end
            gx = $urandom; gy = $urandom; gz = $urandom;
            model(gx, gy, gz, rf, ra, rd, ex, ey, ez, ec);
            run_step(gx, gy, gz, rf, ra, rd, int'($urandom_range(1, 6)),
                     $sformatf("rnd%0d", n), gx, gy, gz, gc);
            chk($sformatf("rnd%0d x_n", n), gx, ex);
            chk($sformatf("rnd%0d y_n", n), gy, ey);
            chk($sformatf("rnd%0d z_n", n), gz, ez);
            chk($sformatf("rnd%0d conv", n), 32'(gc), 32'(ec));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
